// File: rtl/bus_memory.sv
// bus_memory: byte RAM answering CPU read/write strobes inside a fixed address window,
// with a side preload port, saturating hit counters and a sticky bus-error flag.
module bus_memory #(
    parameter logic [15:0] BASE      = 16'h2000,
    parameter int          ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          adress_bus,
    inout  wire  [7:0]           date_bus,
    input  logic                 r,
    input  logic                 w,
    input  logic                 load_valid,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [7:0]           load_data,
    output logic                 load_ready,
    output logic [15:0]          read_count,
    output logic [15:0]          write_count,
    output logic                 bus_error
);
    typedef enum logic [1:0] {IDLE, WRITE, LOAD} state_t;

    state_t               state;
    logic [7:0]           mem [2**ADDR_BITS];
    logic [ADDR_BITS-1:0] offset, wr_off, mem_addr;
    logic [7:0]           wr_data, mem_wd;
    logic                 hit, collide, drive, mem_we;

    assign hit      = adress_bus[15:ADDR_BITS] == BASE[15:ADDR_BITS];
    assign offset   = adress_bus[ADDR_BITS-1:0];
    assign collide  = r & w & hit;
    // Reset releases the bus immediately, independent of the clock.
    assign drive    = reset & r & ~w & hit & (state != LOAD);
    assign date_bus = drive ? mem[offset] : 8'bz;

    assign mem_we   = reset & (state == LOAD ? load_valid : state == WRITE & ~r & ~w);
    assign mem_addr = state == LOAD ? load_addr : wr_off;
    assign mem_wd   = state == LOAD ? load_data : wr_data;

    always_ff @(posedge clk)
        if (mem_we) mem[mem_addr] <= mem_wd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            load_ready  <= 1'b0;
            read_count  <= 16'd0;
            write_count <= 16'd0;
            bus_error   <= 1'b0;
            wr_off      <= '0;
            wr_data     <= 8'd0;
        end else begin
            if (collide) bus_error <= 1'b1;
            case (state)
                IDLE: begin
                    load_ready <= 1'b0;
                    if (w & ~r & hit) begin
                        state   <= WRITE;
                        wr_off  <= offset;
                        wr_data <= date_bus;
                    end else if (load_valid & ~r & ~w)
                        state <= LOAD;
                    else if (r & ~w & hit & (read_count != 16'hFFFF))
                        read_count <= read_count + 16'd1;
                end
                WRITE: begin
                    // Commit happens on the first edge after w is released.
                    if (r) begin
                        bus_error <= 1'b1;
                        state     <= IDLE;
                    end else if (w) begin
                        wr_off  <= offset;
                        wr_data <= date_bus;
                    end else begin
                        if (write_count != 16'hFFFF) write_count <= write_count + 16'd1;
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    load_ready <= load_valid;
                    if (r | w) begin
                        bus_error <= 1'b1;
                        state     <= IDLE;
                    end else if (!load_valid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_memory.sv
// tb_bus_memory: directed bus/load-port stimulus checked against an address-keyed memory
// model and counter model, compared every cycle, plus hand-computed literal expectations.
module tb_bus_memory;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] adress_bus = 16'h0000;
    logic        r = 1'b0, w = 1'b0, load_valid = 1'b0;
    logic [11:0] load_addr = 12'h000;
    logic [7:0]  load_data = 8'h00;
    logic        drv_en = 1'b1;
    logic [7:0]  drv_val = 8'h00;
    logic        load_ready, bus_error;
    logic [15:0] read_count, write_count;
    wire  [7:0]  date_bus;

    assign date_bus = drv_en ? drv_val : 8'bz;

    always #5 clk = ~clk;

    bus_memory #(.BASE(16'h2000), .ADDR_BITS(12)) dut (
        .clk(clk), .reset(reset), .adress_bus(adress_bus), .date_bus(date_bus),
        .r(r), .w(w), .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .load_ready(load_ready), .read_count(read_count), .write_count(write_count),
        .bus_error(bus_error)
    );

    int         vectors = 0, miscompares = 0;
    logic [7:0] mem_m [int];
    int         rc_m = 0, wc_m = 0, pulses = 0;
    logic       err_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bench never drives while it expects read data; otherwise any DUT drive corrupts drv_val.
    always @(negedge clk) if (reset) begin
        chk("read_count", {16'd0, read_count}, rc_m);
        chk("write_count", {16'd0, write_count}, wc_m);
        chk("bus_error", {31'd0, bus_error}, {31'd0, err_m});
        if (r && !w && adress_bus >= 16'h2000 && adress_bus < 16'h3000 && mem_m.exists(int'(adress_bus)))
            chk("bus_read", {24'd0, date_bus}, {24'd0, mem_m[int'(adress_bus)]});
        else if (drv_en)
            chk("bus_undriven", {24'd0, date_bus}, {24'd0, drv_val});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        r = 1'b0; w = 1'b0; load_valid = 1'b0; drv_en = 1'b1; drv_val = 8'h00;
    endtask

    task automatic load(input logic [11:0] a, input logic [7:0] d);
        bit got = 0;
        load_valid = 1'b1; load_addr = a; load_data = d;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (load_ready) begin
                got = 1;
                break;
            end
        end
        if (got) begin
            mem_m[16'h2000 + int'(a)] = d;
            pulses++;
        end else
            chk("load_timeout", 32'd0, 32'd1);
    endtask

    task automatic load_end();
        load_valid = 1'b0;
        cyc();
        chk("load_ready_low", {31'd0, load_ready}, 32'd0);
    endtask

    task automatic read_hit(input logic [15:0] a, input logic [7:0] e);
        adress_bus = a; r = 1'b1; w = 1'b0; drv_en = 1'b0;
        #1;
        chk("read_literal", {24'd0, date_bus}, {24'd0, e});
        cyc();
        rc_m = rc_m == 65535 ? 65535 : rc_m + 1;
        idle();
    endtask

    task automatic read_miss(input logic [15:0] a);
        adress_bus = a; r = 1'b1; w = 1'b0; drv_en = 1'b1; drv_val = 8'h00;
        #1;
        chk("miss_nodrive", {24'd0, date_bus}, 32'd0);
        cyc();
        idle();
    endtask

    task automatic write2(input logic [15:0] a, input logic [7:0] d1, input logic [7:0] d2);
        adress_bus = a; w = 1'b1; r = 1'b0; drv_en = 1'b1; drv_val = d1;
        cyc();
        drv_val = d2;
        cyc();
        w = 1'b0; drv_val = 8'h00;
        cyc();
        mem_m[int'(a)] = d2;
        wc_m++;
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        chk("rst_load_ready", {31'd0, load_ready}, 32'd0);
        chk("rst_read_count", {16'd0, read_count}, 32'd0);
        chk("rst_write_count", {16'd0, write_count}, 32'd0);
        chk("rst_bus_error", {31'd0, bus_error}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        load(12'h000, 8'hA1); load(12'h001, 8'hB2); load(12'h002, 8'hC3); load(12'h003, 8'hD4);
        load_end();
        chk("load_pulses", pulses, 32'd4);
        load(12'h004, 8'h44); load(12'h020, 8'h33); load(12'hFFF, 8'hEE); load(12'h030, 8'h66);
        load_end();
        chk("load_pulses_total", pulses, 32'd8);

        read_hit(16'h2000, 8'hA1); read_hit(16'h2001, 8'hB2);
        read_hit(16'h2002, 8'hC3); read_hit(16'h2003, 8'hD4);
        chk("read_count_4", {16'd0, read_count}, 32'd4);

        write2(16'h2010, 8'h11, 8'h5A);
        read_hit(16'h2010, 8'h5A);
        chk("write_count_1", {16'd0, write_count}, 32'd1);

        read_miss(16'h1FFF);
        read_miss(16'h3000);
        chk("miss_read_count", {16'd0, read_count}, 32'd5);
        chk("miss_no_error", {31'd0, bus_error}, 32'd0);

        // Collision at 2004: flag set, no drive, contents untouched.
        adress_bus = 16'h2004; r = 1'b1; w = 1'b1; drv_en = 1'b1; drv_val = 8'h00;
        #1 chk("collide_nodrive", {24'd0, date_bus}, 32'd0);
        cyc();
        err_m = 1'b1;
        idle();
        cyc();
        read_hit(16'h2004, 8'h44);
        chk("error_sticky", {31'd0, bus_error}, 32'd1);

        // Reset in the middle of a write to 2020.
        adress_bus = 16'h2020; w = 1'b1; drv_val = 8'h77;
        cyc();
        reset = 1'b0; w = 1'b0; r = 1'b1; adress_bus = 16'h2000; drv_val = 8'h00;
        rc_m = 0; wc_m = 0; err_m = 1'b0;
        #1;
        chk("midrst_nodrive", {24'd0, date_bus}, 32'd0);
        chk("midrst_counts", {read_count, write_count}, 32'd0);
        chk("midrst_error", {31'd0, bus_error}, 32'd0);
        r = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        read_hit(16'h2020, 8'h33);

        // Read strobe during a pending write drops it and flags the error.
        adress_bus = 16'h2030; w = 1'b1; drv_val = 8'h99;
        cyc();
        r = 1'b1; drv_val = 8'h00;
        cyc();
        err_m = 1'b1;
        idle();
        cyc();
        read_hit(16'h2030, 8'h66);
        chk("dropped_write_count", {16'd0, write_count}, 32'd0);

        adress_bus = 16'h2000; r = 1'b1; w = 1'b0; drv_en = 1'b0;
        repeat (65540) begin
            cyc();
            rc_m = rc_m == 65535 ? 65535 : rc_m + 1;
        end
        chk("read_count_sat", {16'd0, read_count}, 32'h0000FFFF);
        idle();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
